// File: rtl/sec_cu_if.sv
// Bundles the stopwatch control inputs and display/status outputs.
//   master: drives tick_1Hz, start_btn, lap_btn, clear; observes outputs
//   slave : the stopwatch itself
interface sec_cu_if;
  logic        tick_1Hz;
  logic        start_btn;
  logic        lap_btn;
  logic        clear;
  logic [16:0] seconds;
  logic [7:0]  disp_hh;
  logic [7:0]  disp_mm;
  logic [7:0]  disp_ss;
  logic        running;
  logic        lap_active;
  logic        overflow;

  modport master (
    output tick_1Hz, start_btn, lap_btn, clear,
    input  seconds, disp_hh, disp_mm, disp_ss, running, lap_active, overflow
  );

  modport slave (
    input  tick_1Hz, start_btn, lap_btn, clear,
    output seconds, disp_hh, disp_mm, disp_ss, running, lap_active, overflow
  );
endinterface

// File: rtl/sec_cu.sv
// Count-up stopwatch with lap hold.
// Counts whole seconds from tick_1Hz while running, keeping a binary total
// and packed-BCD HH/MM/SS in lockstep. A lap freezes the displayed value
// while counting continues underneath.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : sec_cu_if.slave
//              in : tick_1Hz, start_btn, lap_btn, clear
//              out: seconds (binary), disp_hh/mm/ss (BCD), running,
//                   lap_active, overflow (sticky wrap flag)
module sec_cu #(
  parameter int unsigned MAX_SEC = 86399
) (
  input  logic     clk,
  input  logic     rst,
  sec_cu_if.slave  bus
);

  localparam logic [16:0] MAX_Q = 17'(MAX_SEC);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  state_t      state, state_n;
  logic        start_q, lap_q;
  logic [16:0] sec_q, sec_n;
  logic [7:0]  hh_q, mm_q, ss_q, hh_n, mm_n, ss_n;
  logic [7:0]  snap_hh, snap_mm, snap_ss, snap_hh_n, snap_mm_n, snap_ss_n;
  logic [7:0]  disp_hh_q, disp_mm_q, disp_ss_q, disp_hh_n, disp_mm_n, disp_ss_n;
  logic        ovf_q, ovf_n;
  logic        start_edge, lap_edge, counting;
  logic [8:0]  ss_inc, mm_inc, hh_inc;

  // Returns {carry, next}; rolls to 00 after 'top', low digit rolls 9->0.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    logic [8:0] r;
    if (v == top)
      r = {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)
      r = {1'b0, v[7:4] + 4'd1, 4'h0};
    else
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    start_edge = bus.start_btn & ~start_q;
    // a start edge in the same clk swallows the lap edge
    lap_edge   = bus.lap_btn & ~lap_q & ~start_edge;
    // gated on the pre-transition state: a tick with a stop still counts,
    // a tick with a start from IDLE/PAUSE does not
    counting   = bus.tick_1Hz & ((state == RUN) | (state == LAP));

    ss_inc = bcd_inc(ss_q, 8'h59);
    mm_inc = bcd_inc(mm_q, 8'h59);
    hh_inc = bcd_inc(hh_q, 8'h23);

    state_n   = state;
    sec_n     = sec_q;
    hh_n      = hh_q;
    mm_n      = mm_q;
    ss_n      = ss_q;
    ovf_n     = ovf_q;
    snap_hh_n = snap_hh;
    snap_mm_n = snap_mm;
    snap_ss_n = snap_ss;

    if (counting) begin
      if (sec_q == MAX_Q) begin
        sec_n = '0;
        hh_n  = '0;
        mm_n  = '0;
        ss_n  = '0;
        ovf_n = 1'b1;
      end else begin
        sec_n = sec_q + 17'd1;
        ss_n  = ss_inc[7:0];
        if (ss_inc[8]) begin
          mm_n = mm_inc[7:0];
          if (mm_inc[8])
            hh_n = hh_inc[7:0];
        end
      end
    end

    case (state)
      IDLE: begin
        if (start_edge)
          state_n = RUN;
      end
      RUN: begin
        if (start_edge)
          state_n = PAUSE;
        else if (lap_edge) begin
          state_n   = LAP;
          snap_hh_n = hh_q;
          snap_mm_n = mm_q;
          snap_ss_n = ss_q;
        end
      end
      LAP: begin
        if (start_edge)
          state_n = PAUSE;
        else if (lap_edge)
          state_n = RUN;
      end
      PAUSE: begin
        if (start_edge)
          state_n = RUN;
        else if (lap_edge) begin
          state_n = IDLE;
          sec_n   = '0;
          hh_n    = '0;
          mm_n    = '0;
          ss_n    = '0;
          ovf_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    // display mux is fed from next-state values so it lands on the same edge
    if (state_n == LAP) begin
      disp_hh_n = snap_hh_n;
      disp_mm_n = snap_mm_n;
      disp_ss_n = snap_ss_n;
    end else begin
      disp_hh_n = hh_n;
      disp_mm_n = mm_n;
      disp_ss_n = ss_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      lap_q     <= 1'b0;
      sec_q     <= '0;
      hh_q      <= '0;
      mm_q      <= '0;
      ss_q      <= '0;
      snap_hh   <= '0;
      snap_mm   <= '0;
      snap_ss   <= '0;
      disp_hh_q <= '0;
      disp_mm_q <= '0;
      disp_ss_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      start_q <= bus.start_btn;
      lap_q   <= bus.lap_btn;
      if (bus.clear) begin
        state     <= IDLE;
        sec_q     <= '0;
        hh_q      <= '0;
        mm_q      <= '0;
        ss_q      <= '0;
        snap_hh   <= '0;
        snap_mm   <= '0;
        snap_ss   <= '0;
        disp_hh_q <= '0;
        disp_mm_q <= '0;
        disp_ss_q <= '0;
        ovf_q     <= 1'b0;
      end else begin
        state     <= state_n;
        sec_q     <= sec_n;
        hh_q      <= hh_n;
        mm_q      <= mm_n;
        ss_q      <= ss_n;
        snap_hh   <= snap_hh_n;
        snap_mm   <= snap_mm_n;
        snap_ss   <= snap_ss_n;
        disp_hh_q <= disp_hh_n;
        disp_mm_q <= disp_mm_n;
        disp_ss_q <= disp_ss_n;
        ovf_q     <= ovf_n;
      end
    end
  end

  assign bus.seconds    = sec_q;
  assign bus.disp_hh    = disp_hh_q;
  assign bus.disp_mm    = disp_mm_q;
  assign bus.disp_ss    = disp_ss_q;
  assign bus.running    = (state == RUN) | (state == LAP);
  assign bus.lap_active = (state == LAP);
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_sec_cu.sv
// Directed testbench for sec_cu: each step pushes its expected outputs onto
// a scoreboard queue, drives stimulus, then pops and compares.
module tb_sec_cu;

  logic clk;
  logic rst;
  sec_cu_if bus ();

  sec_cu #(.MAX_SEC(86399)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] sec;
    logic [7:0]  hh, mm, ss;
    logic        run, lap, ovf;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic expect_out(input string tag, input int sec,
                            input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                            input logic run, input logic lap, input logic ovf);
    exp_t e;
    e.tag = tag; e.sec = 17'(sec);
    e.hh = hh; e.mm = mm; e.ss = ss;
    e.run = run; e.lap = lap; e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [16:0] got, input logic [16:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "seconds",    bus.seconds,           e.sec);
      cmp(e.tag, "disp_hh",    17'(bus.disp_hh),      17'(e.hh));
      cmp(e.tag, "disp_mm",    17'(bus.disp_mm),      17'(e.mm));
      cmp(e.tag, "disp_ss",    17'(bus.disp_ss),      17'(e.ss));
      cmp(e.tag, "running",    17'(bus.running),      17'(e.run));
      cmp(e.tag, "lap_active", 17'(bus.lap_active),   17'(e.lap));
      cmp(e.tag, "overflow",   17'(bus.overflow),     17'(e.ovf));
    end
  endtask

  // One clk with the given inputs high, returning at the following negedge.
  task automatic step(input logic s, input logic l, input logic t);
    @(negedge clk);
    bus.start_btn = s;
    bus.lap_btn   = l;
    bus.tick_1Hz  = t;
    @(negedge clk);
    bus.start_btn = 1'b0;
    bus.lap_btn   = 1'b0;
    bus.tick_1Hz  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.tick_1Hz  = 1'b0;
    bus.start_btn = 1'b0;
    bus.lap_btn   = 1'b0;
    bus.clear     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_out("reset", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    check_out();

    // count to 37 then hit async reset mid-count
    expect_out("run37", 37, 8'h00, 8'h00, 8'h37, 1, 0, 0);
    step(1, 0, 0); ticks(37);
    check_out();
    expect_out("async_rst", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_out();
    @(negedge clk);
    rst = 1'b0;

    expect_out("idle_ticks", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    ticks(5);
    check_out();

    expect_out("run75", 75, 8'h00, 8'h01, 8'h15, 1, 0, 0);
    step(1, 0, 0); ticks(75);
    check_out();

    expect_out("pause75", 75, 8'h00, 8'h01, 8'h15, 0, 0, 0);
    step(1, 0, 0); ticks(10);
    check_out();

    expect_out("pause_lap_idle", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    step(0, 1, 0);
    check_out();

    expect_out("lap_enter_9", 12, 8'h00, 8'h00, 8'h09, 1, 1, 0);
    step(1, 0, 0); ticks(9); step(0, 1, 0); ticks(3);
    check_out();

    expect_out("lap_exit_12", 12, 8'h00, 8'h00, 8'h12, 1, 0, 0);
    step(0, 1, 0);
    check_out();

    expect_out("start_lap_same", 12, 8'h00, 8'h00, 8'h12, 0, 0, 0);
    step(1, 1, 0);
    check_out();

    expect_out("reidle", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    step(0, 1, 0);
    check_out();

    expect_out("stop_with_tick", 6, 8'h00, 8'h00, 8'h06, 0, 0, 0);
    step(1, 0, 0); ticks(5); step(1, 0, 1);
    check_out();

    expect_out("paused_ticks", 6, 8'h00, 8'h00, 8'h06, 0, 0, 0);
    ticks(3);
    check_out();

    expect_out("start_with_tick", 6, 8'h00, 8'h00, 8'h06, 1, 0, 0);
    step(1, 0, 1);
    check_out();

    expect_out("pause120", 120, 8'h00, 8'h02, 8'h00, 0, 0, 0);
    ticks(114); step(1, 0, 0);
    check_out();

    expect_out("pause120_lap", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    step(0, 1, 0);
    check_out();

    // preload the count to MAX_SEC-1 (23:59:58) while running
    step(1, 0, 0);
    @(negedge clk);
    force dut.sec_q = 17'd86398;
    force dut.hh_q  = 8'h23;
    force dut.mm_q  = 8'h59;
    force dut.ss_q  = 8'h58;
    #1;
    release dut.sec_q;
    release dut.hh_q;
    release dut.mm_q;
    release dut.ss_q;

    expect_out("max_sec", 86399, 8'h23, 8'h59, 8'h59, 1, 0, 0);
    ticks(1);
    check_out();

    expect_out("wrap", 0, 8'h00, 8'h00, 8'h00, 1, 0, 1);
    ticks(1);
    check_out();

    expect_out("after_wrap", 3, 8'h00, 8'h00, 8'h03, 1, 0, 1);
    ticks(3);
    check_out();

    // clear during RUN, coinciding with a tick
    expect_out("clear", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    @(negedge clk);
    bus.clear    = 1'b1;
    bus.tick_1Hz = 1'b1;
    @(negedge clk);
    bus.tick_1Hz = 1'b0;
    check_out();

    // start pressed while clear held: history follows the button, no action
    expect_out("clear_held", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    bus.start_btn = 1'b1;
    @(negedge clk);
    bus.tick_1Hz = 1'b1;
    @(negedge clk);
    bus.tick_1Hz = 1'b0;
    check_out();

    expect_out("clear_release_no_edge", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    bus.clear = 1'b0;
    repeat (2) @(negedge clk);
    check_out();

    // button held through reset yields one edge after release
    expect_out("held_through_rst", 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_out();
    bus.start_btn = 1'b0;

    expect_out("held_then_ticks", 2, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    ticks(2);
    check_out();

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d entries expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
